// File: rtl/adxl362_pkg.sv
// rtl/adxl362_pkg.sv - ADXL362 SPI responder constants, state type and register reset values
package adxl362_pkg;

    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] CMD_READ       = 8'h0B;

    localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
    localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
    localparam logic [5:0] ADDR_PARTID    = 6'h02;
    localparam logic [5:0] ADDR_REVID     = 6'h03;
    localparam logic [5:0] ADDR_LAST_RO   = 6'h03;
    localparam logic [5:0] ADDR_SOFT_RST  = 6'h1F;

    localparam logic [7:0] RST_DEVID_AD   = 8'hAD;
    localparam logic [7:0] RST_DEVID_MST  = 8'h1D;
    localparam logic [7:0] RST_PARTID     = 8'hF2;
    localparam logic [7:0] RST_REVID      = 8'h01;

    localparam logic [7:0] SOFT_RESET_KEY = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_IGNORE
    } spi_state_t;

    // Power-on / soft-reset content of one register.
    function automatic logic [7:0] reg_reset_value(input logic [5:0] addr);
        case (addr)
            ADDR_DEVID_AD:  reg_reset_value = RST_DEVID_AD;
            ADDR_DEVID_MST: reg_reset_value = RST_DEVID_MST;
            ADDR_PARTID:    reg_reset_value = RST_PARTID;
            ADDR_REVID:     reg_reset_value = RST_REVID;
            default:        reg_reset_value = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchronizer with rise/fall pulse outputs
module spi_sync_edge #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    // Two synchronizer stages plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= IDLE_LEVEL;
            sync <= IDLE_LEVEL;
            prev <= IDLE_LEVEL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign dout = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_adxl362_responder.sv
// rtl/spi_adxl362_responder.sv - SPI mode-0 responder emulating the ADXL362 register interface
module spi_adxl362_responder
    import adxl362_pkg::*;
#(
    parameter int CLK_FREQUENCY      = 100_000_000,
    parameter int SCLK_MAX_FREQUENCY = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SPI_SCLK,
    input  logic       SPI_CS,
    input  logic       SPI_MOSI,
    output logic       SPI_MISO,
    output logic       reg_wr_valid,
    output logic [5:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       frame_done
);

    // Each SCLK half-period must span at least four system clocks; an instance
    // configured with less oversampling stays silent instead of misbehaving.
    localparam logic RATIO_OK = (CLK_FREQUENCY >= 8 * SCLK_MAX_FREQUENCY);

    spi_state_t state;
    spi_state_t state_nxt;

    logic       sclk_s, sclk_rise, sclk_fall;
    logic       cs_s, cs_rise, cs_fall;
    logic       mosi_meta, mosi_s;

    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [5:0] ptr;
    logic       is_read;
    logic       sr_pending;
    logic [1:0] settle;
    logic       armed;
    logic [7:0] regs [64];

    logic [7:0] rx_byte;
    logic       frame_start;
    logic       bit_strobe;
    logic       byte_done;

    spi_sync_edge #(.IDLE_LEVEL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SPI_SCLK),
        .dout (sclk_s),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.IDLE_LEVEL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SPI_CS),
        .dout (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // MOSI only needs its level, aligned with the SCLK synchronizer delay.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= SPI_MOSI;
            mosi_s    <= mosi_meta;
        end
    end

    assign rx_byte     = {shift[6:0], mosi_s};
    assign frame_start = cs_fall & armed & RATIO_OK;
    assign bit_strobe  = sclk_rise & ~cs_s & (state != ST_IDLE);
    assign byte_done   = bit_strobe & (bit_cnt == 3'd7);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: a CS fall always restarts, CS high always aborts.
    always_comb begin
        state_nxt = state;
        if (frame_start) begin
            state_nxt = ST_CMD;
        end else if (cs_s) begin
            state_nxt = ST_IDLE;
        end else if (byte_done) begin
            case (state)
                ST_CMD: begin
                    if (rx_byte == CMD_WRITE || rx_byte == CMD_READ) begin
                        state_nxt = ST_ADDR;
                    end else begin
                        state_nxt = ST_IGNORE;
                    end
                end
                ST_ADDR:  state_nxt = is_read ? ST_RD_DATA : ST_WR_DATA;
                default:  state_nxt = state;
            endcase
        end
    end

    // After reset, wait until the bus is seen idle before accepting a frame so
    // that a transfer interrupted by reset is not picked up half-way.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle <= 2'd0;
            armed  <= 1'b0;
        end else if (settle != 2'd3) begin
            settle <= settle + 2'd1;
        end else if (cs_s && !sclk_s) begin
            armed <= 1'b1;
        end
    end

    // Bit shifting, pointer handling, register writes and frame-end events.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt      <= 3'd0;
            shift        <= 8'h00;
            ptr          <= 6'd0;
            is_read      <= 1'b0;
            sr_pending   <= 1'b0;
            reg_wr_valid <= 1'b0;
            reg_wr_addr  <= 6'd0;
            reg_wr_data  <= 8'h00;
            frame_done   <= 1'b0;
            for (int i = 0; i < 64; i++) begin
                regs[i] <= reg_reset_value(6'(i));
            end
        end else begin
            reg_wr_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (cs_rise) begin
                frame_done <= 1'b1;
                bit_cnt    <= 3'd0;
                sr_pending <= 1'b0;
                if (sr_pending) begin
                    for (int i = 0; i < 64; i++) begin
                        regs[i] <= reg_reset_value(6'(i));
                    end
                end
            end else if (frame_start) begin
                bit_cnt <= 3'd0;
                shift   <= 8'h00;
            end else if (bit_strobe) begin
                shift   <= rx_byte;
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    case (state)
                        ST_CMD:  is_read <= (rx_byte == CMD_READ);
                        ST_ADDR: ptr     <= rx_byte[5:0];
                        ST_WR_DATA: begin
                            if (ptr > ADDR_LAST_RO) begin
                                regs[ptr]    <= rx_byte;
                                reg_wr_valid <= 1'b1;
                                reg_wr_addr  <= ptr;
                                reg_wr_data  <= rx_byte;
                            end
                            if (ptr == ADDR_SOFT_RST && rx_byte == SOFT_RESET_KEY) begin
                                sr_pending <= 1'b1;
                            end
                            ptr <= ptr + 6'd1;
                        end
                        ST_RD_DATA: ptr <= ptr + 6'd1;
                        default: ;
                    endcase
                end
            end
        end
    end

    // MISO: driven only in a read data phase, updated on SCLK falls; the bit
    // counter has wrapped to 0 at a byte boundary so bit 7 leads each byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SPI_MISO <= 1'b0;
        end else if (cs_fall || cs_s || state != ST_RD_DATA) begin
            SPI_MISO <= 1'b0;
        end else if (sclk_fall) begin
            SPI_MISO <= regs[ptr][~bit_cnt];
        end
    end

endmodule

// File: tb/tb_spi_adxl362_responder.sv
// tb/tb_spi_adxl362_responder.sv - scoreboard bench for spi_adxl362_responder
module tb_spi_adxl362_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       SPI_SCLK = 1'b0;
    logic       SPI_CS = 1'b1;
    logic       SPI_MOSI = 1'b0;
    logic       SPI_MISO;
    logic       reg_wr_valid;
    logic [5:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic       frame_done;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    logic [7:0]  tx_buf [16];
    logic [7:0]  mregs [64];
    logic [13:0] exp_wr_q [$];
    logic [7:0]  exp_miso_q [$];

    logic [7:0]  mon_byte = 8'h00;
    int          mon_bits = 0;

    spi_adxl362_responder #(
        .CLK_FREQUENCY      (100_000_000),
        .SCLK_MAX_FREQUENCY (1_000_000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .SPI_SCLK     (SPI_SCLK),
        .SPI_CS       (SPI_CS),
        .SPI_MOSI     (SPI_MOSI),
        .SPI_MISO     (SPI_MISO),
        .reg_wr_valid (reg_wr_valid),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) mregs[i] = 8'h00;
        mregs[0] = 8'hAD;
        mregs[1] = 8'h1D;
        mregs[2] = 8'hF2;
        mregs[3] = 8'h01;
    endfunction

    // Reference model: interpret a whole frame of nb complete bytes.
    task automatic model_frame(input int nb);
        logic [7:0] cmd;
        logic [5:0] p;
        logic [7:0] e;
        logic       sr;
        cmd = tx_buf[0];
        p   = tx_buf[1][5:0];
        sr  = 1'b0;
        for (int i = 0; i < nb; i++) begin
            e = 8'h00;
            if (i >= 2 && cmd == 8'h0B) begin
                e = mregs[p];
                p = p + 6'd1;
            end else if (i >= 2 && cmd == 8'h0A) begin
                if (p > 6'd3) begin
                    mregs[p] = tx_buf[i];
                    exp_wr_q.push_back({p, tx_buf[i]});
                end
                if (p == 6'h1F && tx_buf[i] == 8'h52) sr = 1'b1;
                p = p + 6'd1;
            end
            exp_miso_q.push_back(e);
        end
        if (sr) model_reset();
    endtask

    // Write monitor: every reg_wr_valid cycle consumes one expected write.
    always @(negedge clk) begin
        if (rst && reg_wr_valid) begin
            if (exp_wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write", reg_wr_addr, reg_wr_data);
            end else begin
                check("wr_event", {18'd0, reg_wr_addr, reg_wr_data}, {18'd0, exp_wr_q.pop_front()});
            end
        end
        if (rst && frame_done) fd_cnt++;
    end

    // MISO monitor: assemble bytes as the controller samples them on SCLK rise.
    always @(posedge SPI_SCLK or posedge SPI_CS) begin
        if (SPI_CS) begin
            mon_bits = 0;
        end else begin
            mon_byte = {mon_byte[6:0], SPI_MISO};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (exp_miso_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_unexpected: got 0x%0h, expected no byte", mon_byte);
                end else begin
                    check("miso_byte", {24'd0, mon_byte}, {24'd0, exp_miso_q.pop_front()});
                end
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input int nbits, input int h);
        logic [7:0] b;
        for (int i = 0; i < nbits; i++) begin
            b = tx_buf[i / 8];
            SPI_MOSI = b[7 - (i % 8)];
            wait_clks(h);
            SPI_SCLK = 1'b1;
            wait_clks(h);
            SPI_SCLK = 1'b0;
        end
    endtask

    task automatic spi_frame(input int nbits, input int h);
        int fd0;
        model_frame(nbits / 8);
        fd0 = fd_cnt;
        @(negedge clk);
        SPI_CS = 1'b0;
        wait_clks(h);
        spi_bits(nbits, h);
        wait_clks(h);
        SPI_CS   = 1'b1;
        SPI_MOSI = 1'b0;
        wait_clks(12);
        check("frame_done_once", fd_cnt - fd0, 1);
        check("miso_idle", {31'd0, SPI_MISO}, 0);
    endtask

    task automatic set3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        tx_buf[0] = a;
        tx_buf[1] = b;
        tx_buf[2] = c;
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) tx_buf[i] = 8'h00;
        model_reset();
        wait_clks(5);
        check("rst_miso", {31'd0, SPI_MISO}, 0);
        check("rst_wr_valid", {31'd0, reg_wr_valid}, 0);
        check("rst_wr_addr", {26'd0, reg_wr_addr}, 0);
        check("rst_wr_data", {24'd0, reg_wr_data}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        rst = 1'b1;
        wait_clks(10);

        // Single read of DEVID_AD at 500 kHz.
        set3(8'h0B, 8'h00, 8'h00);
        spi_frame(24, 100);

        // Write then read back.
        set3(8'h0A, 8'h20, 8'h5A);
        spi_frame(24, 50);
        set3(8'h0B, 8'h20, 8'h00);
        spi_frame(24, 50);

        // Burst read of the ID registers.
        set3(8'h0B, 8'h00, 8'h00);
        for (int i = 3; i < 6; i++) tx_buf[i] = 8'h00;
        spi_frame(48, 50);

        // Burst write wrapping 0x3F -> 0x00 (discarded), then read across the wrap.
        set3(8'h0A, 8'h3F, 8'h11);
        tx_buf[3] = 8'h22;
        spi_frame(32, 50);
        set3(8'h0B, 8'hFF, 8'h00);
        tx_buf[3] = 8'h00;
        spi_frame(32, 50);

        // Unknown command, full and truncated, then a normal frame.
        set3(8'h0C, 8'hA5, 8'h00);
        spi_frame(16, 50);
        set3(8'h0C, 8'hFF, 8'h00);
        spi_frame(11, 50);
        set3(8'h0B, 8'h20, 8'h00);
        spi_frame(24, 50);

        // Soft reset clears user registers at frame end.
        set3(8'h0A, 8'h1F, 8'h52);
        spi_frame(24, 50);
        set3(8'h0B, 8'h20, 8'h00);
        spi_frame(24, 50);
        set3(8'h0B, 8'h1F, 8'h00);
        spi_frame(24, 50);

        // Reset asserted after 4 data bits of a write.
        set3(8'h0A, 8'h25, 8'hC3);
        exp_miso_q.push_back(8'h00);
        exp_miso_q.push_back(8'h00);
        @(negedge clk);
        SPI_CS = 1'b0;
        wait_clks(50);
        spi_bits(20, 50);
        rst = 1'b0;
        wait_clks(1);
        check("midrst_miso", {31'd0, SPI_MISO}, 0);
        check("midrst_wr_valid", {31'd0, reg_wr_valid}, 0);
        check("midrst_wr_addr", {26'd0, reg_wr_addr}, 0);
        check("midrst_frame_done", {31'd0, frame_done}, 0);
        SPI_CS   = 1'b1;
        SPI_MOSI = 1'b0;
        wait_clks(5);
        rst = 1'b1;
        model_reset();
        wait_clks(10);
        set3(8'h0A, 8'h25, 8'h77);
        spi_frame(24, 50);
        set3(8'h0B, 8'h25, 8'h00);
        spi_frame(24, 50);

        // Randomized frames against the model.
        for (int f = 0; f < 6; f++) begin
            int kind;
            int nb;
            kind = $urandom_range(0, 2);
            nb   = 2 + $urandom_range(1, 4);
            if (kind == 0) tx_buf[0] = 8'h0A;
            else if (kind == 1) tx_buf[0] = 8'h0B;
            else tx_buf[0] = 8'h10 + 8'($urandom_range(0, 200));
            tx_buf[1] = 8'($urandom);
            for (int i = 2; i < nb; i++) tx_buf[i] = 8'($urandom);
            spi_frame(nb * 8, 25);
        end

        wait_clks(20);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("miso_queue_drained", exp_miso_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
